// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, region select
// and STATUS register bit positions.
package dmem_pkg;

   // Word offsets within the MMIO page (dat_a[11:0], low two bits forced to zero)
   localparam logic [11:0] OFS_TXDATA   = 12'h000;
   localparam logic [11:0] OFS_STATUS   = 12'h004;
   localparam logic [11:0] OFS_MTIME    = 12'h008;
   localparam logic [11:0] OFS_MTIMECMP = 12'h00C;

   typedef enum logic {
      REG_RAM,
      REG_MMIO
   } region_e;

   // STATUS = {22'b0, ovf, full, count[7:0]}
   localparam int unsigned ST_COUNT_LSB = 0;
   localparam int unsigned ST_FULL_BIT  = 8;
   localparam int unsigned ST_OVF_BIT   = 9;

endpackage

// File: rtl/u_txq.sv
// Console TX byte FIFO: power-of-two depth, pop on valid && ready, push accepted
// when not full or when full with a same-cycle pop; dropped pushes set sticky ovf.
module u_txq #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [7:0]                 din,
   input  logic                       ready,
   input  logic                       clr_ovf,
   output logic                       valid,
   output logic [7:0]                 dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       ovf
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          pop;
   logic          push_ok;

   assign valid   = (count_q != '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop     = valid && ready;
   assign push_ok = push && (!full || pop);
   assign count   = count_q;
   assign ovf     = ovf_q;
   // Head byte is forced to zero when empty so a reset FIFO shows tx_data = 0
   assign dout    = valid ? fifo_mem[rd_ptr_q] : 8'h00;

   // Next-state for pointers, occupancy and sticky overflow
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end else if (push && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage write; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/u_dmem.sv
// Data-SRAM port responder: byte-lane RAM plus an MMIO page holding the console
// TX queue and an optional cycle timer (enabled by defining DMEM_TIMER_EN).
// Read data is registered: a request in cycle N shows on dat_rd in cycle N+1.
module u_dmem
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned TXQ_DEPTH   = 4,
   parameter logic [3:0]  MMIO_PAGE   = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] dat_a,
   input  logic [3:0]  dat_we,
   input  logic [31:0] dat_wd,
   input  logic [3:0]  dat_re,
   output logic [31:0] dat_rd,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(TXQ_DEPTH) + 1;

   region_e        region;
   logic [11:0]    ofs;
   logic [AW-1:0]  idx;
   logic [31:0]    mem [DEPTH_WORDS];
   logic [31:0]    mmio_rd;
   logic [31:0]    status_word;
   logic [31:0]    mtime_rd;
   logic [31:0]    mtimecmp_rd;
   logic           txq_push;
   logic           txq_clr_ovf;
   logic [CW-1:0]  txq_count;
   logic           txq_full;
   logic           txq_ovf;
   logic           unused_addr;

   assign region = (dat_a[15:12] == MMIO_PAGE) ? REG_MMIO : REG_RAM;
   assign ofs    = {dat_a[11:2], 2'b00};
   // Upper address bits beyond the RAM index are ignored, so RAM aliases modulo its size
   assign idx    = dat_a[AW+1:2];
   assign unused_addr = ^dat_a;

   assign txq_push    = (region == REG_MMIO) && (ofs == OFS_TXDATA) && dat_we[0];
   assign txq_clr_ovf = (region == REG_MMIO) && (ofs == OFS_STATUS) && (dat_we != 4'b0000);

   u_txq #(
      .DEPTH (TXQ_DEPTH)
   ) txq (
      .clk     (clk),
      .rst     (rst),
      .push    (txq_push),
      .din     (dat_wd[7:0]),
      .ready   (tx_ready),
      .clr_ovf (txq_clr_ovf),
      .valid   (tx_valid),
      .dout    (tx_data),
      .count   (txq_count),
      .full    (txq_full),
      .ovf     (txq_ovf)
   );

   // Byte-lane RAM write; unwritten lanes keep their contents
   always_ff @(posedge clk) begin
      if (region == REG_RAM) begin
         for (int i = 0; i < 4; i++) begin
            if (dat_we[i]) mem[idx][8*i +: 8] <= dat_wd[8*i +: 8];
         end
      end
   end

`ifdef DMEM_TIMER_EN
   logic [31:0] mtime_q, mtime_d;
   logic [31:0] mtimecmp_q, mtimecmp_d;
   logic        irq_q;

   // Timer next-state: a lane load of MTIME replaces that cycle's increment
   always_comb begin
      mtime_d    = mtime_q + 32'd1;
      mtimecmp_d = mtimecmp_q;
      if ((region == REG_MMIO) && (ofs == OFS_MTIME) && (dat_we != 4'b0000)) begin
         mtime_d = mtime_q;
         for (int i = 0; i < 4; i++) begin
            if (dat_we[i]) mtime_d[8*i +: 8] = dat_wd[8*i +: 8];
         end
      end
      if ((region == REG_MMIO) && (ofs == OFS_MTIMECMP)) begin
         for (int i = 0; i < 4; i++) begin
            if (dat_we[i]) mtimecmp_d[8*i +: 8] = dat_wd[8*i +: 8];
         end
      end
   end

   // Timer registers; irq compares pre-increment mtime so it lags one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= 32'h0000_0000;
         mtimecmp_q <= 32'hFFFF_FFFF;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         irq_q      <= (mtime_q >= mtimecmp_q);
      end
   end

   assign timer_irq   = irq_q;
   assign mtime_rd    = mtime_q;
   assign mtimecmp_rd = mtimecmp_q;
`else
   assign timer_irq   = 1'b0;
   assign mtime_rd    = 32'h0000_0000;
   assign mtimecmp_rd = 32'h0000_0000;
`endif

   // MMIO read mux; STATUS reflects the FIFO before any same-cycle push/pop
   always_comb begin
      status_word = 32'h0000_0000;
      status_word[ST_COUNT_LSB +: 8] = 8'(txq_count);
      status_word[ST_FULL_BIT]       = txq_full;
      status_word[ST_OVF_BIT]        = txq_ovf;
      mmio_rd = 32'h0000_0000;
      case (ofs)
         OFS_STATUS:   mmio_rd = status_word;
         OFS_MTIME:    mmio_rd = mtime_rd;
         OFS_MTIMECMP: mmio_rd = mtimecmp_rd;
         default:      mmio_rd = 32'h0000_0000;
      endcase
   end

   // Registered read data; RAM read sees the old word on a same-cycle write
   always_ff @(posedge clk) begin
      if (rst) begin
         dat_rd <= 32'h0000_0000;
      end else if (dat_re != 4'b0000) begin
         dat_rd <= (region == REG_RAM) ? mem[idx] : mmio_rd;
      end
   end

endmodule

// File: tb/tb_u_dmem.sv
// Directed self-checking bench for u_dmem: RAM lanes, aliasing, read-before-write,
// TX FIFO overflow/drain/full-push, timer (DMEM_TIMER_EN) and mid-run reset.
module tb_u_dmem;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] dat_a;
   logic [3:0]  dat_we;
   logic [31:0] dat_wd;
   logic [3:0]  dat_re;
   logic [31:0] dat_rd;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        timer_irq;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rdata;

   u_dmem dut (
      .clk       (clk),
      .rst       (rst),
      .dat_a     (dat_a),
      .dat_we    (dat_we),
      .dat_wd    (dat_wd),
      .dat_re    (dat_re),
      .dat_rd    (dat_rd),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd);
      dat_a  = a;
      dat_we = we;
      dat_wd = wd;
      @(posedge clk);
      #1;
      dat_we = 4'h0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
      dat_a  = a;
      dat_re = 4'hF;
      @(posedge clk);
      #1;
      dat_re = 4'h0;
      d = dat_rd;
   endtask

   initial begin
      rst      = 1'b1;
      dat_a    = 16'h0000;
      dat_we   = 4'h0;
      dat_wd   = 32'h0;
      dat_re   = 4'h0;
      tx_ready = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check_eq("rst_dat_rd", dat_rd, 32'h0);
      check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      check_eq("rst_tx_data", {24'b0, tx_data}, 32'h0);
      check_eq("rst_irq", {31'b0, timer_irq}, 32'h0);
      bus_read(16'hF008, rdata);
      check_eq("rst_mtime", rdata, 32'h0);
      bus_read(16'hF00C, rdata);
`ifdef DMEM_TIMER_EN
      check_eq("rst_mtimecmp", rdata, 32'hFFFF_FFFF);
`else
      check_eq("rst_mtimecmp", rdata, 32'h0);
`endif
      bus_read(16'hF004, rdata);
      check_eq("rst_status", rdata, 32'h0);

      // RAM byte lanes
      bus_write(16'h0010, 4'hF, 32'hDEAD_BEEF);
      bus_write(16'h0010, 4'b0010, 32'h0000_5500);
      bus_read(16'h0010, rdata);
      check_eq("ram_lane", rdata, 32'hDEAD_55EF);

      // Address wrap modulo DEPTH_WORDS
      bus_write(16'h0010, 4'hF, 32'h1234_5678);
      bus_read(16'h4010, rdata);
      check_eq("ram_wrap", rdata, 32'h1234_5678);

      // Read-before-write, then hold when no read request
      bus_write(16'h0020, 4'hF, 32'hAAAA_AAAA);
      dat_a  = 16'h0020;
      dat_we = 4'hF;
      dat_wd = 32'h5555_5555;
      dat_re = 4'hF;
      @(posedge clk);
      #1;
      dat_we = 4'h0;
      dat_re = 4'h0;
      check_eq("rbw_old", dat_rd, 32'hAAAA_AAAA);
      bus_read(16'h0020, rdata);
      check_eq("rbw_new", rdata, 32'h5555_5555);
      @(posedge clk);
      #1;
      check_eq("rd_hold", dat_rd, 32'h5555_5555);

      // Unmapped/write-only MMIO reads return zero
      bus_read(16'hF000, rdata);
      check_eq("txdata_rd", rdata, 32'h0);
      bus_read(16'hF010, rdata);
      check_eq("unmapped_rd", rdata, 32'h0);

      // FIFO overflow, then drain
      for (int i = 0; i < 5; i++) bus_write(16'hF000, 4'h1, 32'h41 + i);
      bus_read(16'hF004, rdata);
      check_eq("ovf_status", rdata, 32'h0000_0304);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("drain_valid", {31'b0, tx_valid}, 32'h1);
         check_eq("drain_data", {24'b0, tx_data}, 32'h41 + i);
         @(posedge clk);
         #1;
      end
      check_eq("drain_empty", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      bus_read(16'hF004, rdata);
      check_eq("ovf_sticky", rdata, 32'h0000_0200);
      bus_write(16'hF004, 4'h1, 32'h0);
      bus_read(16'hF004, rdata);
      check_eq("ovf_clear", rdata, 32'h0);

      // Push into a full FIFO with a same-cycle pop
      for (int i = 0; i < 4; i++) bus_write(16'hF000, 4'h1, 32'h41 + i);
      tx_ready = 1'b1;
      bus_write(16'hF000, 4'h1, 32'h46);
      tx_ready = 1'b0;
      bus_read(16'hF004, rdata);
      check_eq("full_push_status", rdata, 32'h0000_0104);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("full_push_data", {24'b0, tx_data}, (i == 3) ? 32'h46 : 32'h42 + i);
         @(posedge clk);
         #1;
      end
      check_eq("full_push_empty", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // Timer
`ifdef DMEM_TIMER_EN
      bus_write(16'hF008, 4'hF, 32'h0000_0000);
      bus_write(16'hF00C, 4'hF, 32'h0000_0010);
      repeat (15) @(posedge clk);
      #1;
      check_eq("irq_before", {31'b0, timer_irq}, 32'h0);
      @(posedge clk);
      #1;
      check_eq("irq_rise", {31'b0, timer_irq}, 32'h1);
      bus_read(16'hF00C, rdata);
      check_eq("mtimecmp_rd", rdata, 32'h0000_0010);
      bus_write(16'hF00C, 4'hF, 32'hFFFF_FFFF);
      check_eq("irq_lag", {31'b0, timer_irq}, 32'h1);
      @(posedge clk);
      #1;
      check_eq("irq_fall", {31'b0, timer_irq}, 32'h0);
`else
      bus_write(16'hF008, 4'hF, 32'h0000_0005);
      bus_write(16'hF00C, 4'hF, 32'h0000_0000);
      repeat (4) @(posedge clk);
      #1;
      check_eq("irq_off", {31'b0, timer_irq}, 32'h0);
      bus_read(16'hF008, rdata);
      check_eq("mtime_off", rdata, 32'h0);
`endif

      // Reset mid-transaction: FIFO holds 3 bytes and a read is pending
      bus_read(16'h0010, rdata);
      check_eq("pre_rst_rd", rdata, 32'h1234_5678);
      for (int i = 0; i < 3; i++) bus_write(16'hF000, 4'h1, 32'h61 + i);
      check_eq("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
      dat_a  = 16'h0010;
      dat_re = 4'hF;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      dat_re = 4'h0;
      check_eq("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
      check_eq("mid_rst_data", {24'b0, tx_data}, 32'h0);
      check_eq("mid_rst_rd", dat_rd, 32'h0);
      bus_read(16'hF004, rdata);
      check_eq("mid_rst_status", rdata, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/u_dmem.md
Name: u_dmem

Overview:
- Responder for the core's data-SRAM port (dat_a/dat_we/dat_wd/dat_re/dat_rd).
- Serves a byte-lane data RAM plus a small MMIO page: console TX queue, 32-bit cycle timer and compare.
- Sits beside the core in the top level, with the instruction SRAM.
- Read data is returned with synchronous-SRAM timing.

Parameters:
- DEPTH_WORDS, 4096: RAM size in 32-bit words; power of two.
- TXQ_DEPTH, 4: console TX FIFO entries; power of two, at least 2.
- MMIO_PAGE, 4'hF: value of dat_a[15:12] that selects MMIO.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- dat_a  in  16  byte address; bits [1:0] ignored, word-aligned.
- dat_we  in  4  byte-lane write enables; lane i = dat_wd[8i+7:8i].
- dat_wd  in  32  write data.
- dat_re  in  4  byte-lane read enables; any bit set = read request.
- dat_rd  out  32  registered read data.
- tx_valid  out  1  console byte available.
- tx_data  out  8  console byte (FIFO head).
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready.
- timer_irq  out  1  timer interrupt, level.

Behaviour:
- Reset values: dat_rd=0, tx_valid=0, tx_data=0, timer_irq=0, FIFO empty, ovf=0, mtime=0, mtimecmp=32'hFFFF_FFFF. Reset mid-transaction discards FIFO contents and any pending read. RAM contents are not reset.
- Region decode: MMIO when dat_a[15:12]==MMIO_PAGE, else RAM. RAM index = dat_a[log2(DEPTH_WORDS)+1:2], which wraps modulo DEPTH_WORDS.
- RAM write: each lane with dat_we[i]=1 is written at the rising edge; other lanes are unchanged.
- Read latency is 1 cycle. If dat_re!=0 in cycle N, the full addressed word appears on dat_rd in cycle N+1, regardless of lane mask. When dat_re==0, dat_rd holds its last value.
- Same-cycle read and write to the same word: read-before-write, so dat_rd returns the old word.
- MMIO map, word offsets from page base:
  - 0x000 TXDATA. Write with dat_we[0]=1 pushes dat_wd[7:0]. Read returns 0.
  - 0x004 STATUS. Read = {22'b0, ovf, full, count[7:0]}, count zero-extended. Any write clears ovf.
  - 0x008 MTIME. Read = mtime. Lane writes load mtime; this load replaces the increment that cycle.
  - 0x00C MTIMECMP. Read/write with lane enables.
  - Other offsets: reads return 0, writes are ignored.
- MMIO reads use the same 1-cycle latency. A STATUS read returns the value before any same-cycle push/pop.
- TX FIFO:
  - tx_valid = count!=0; tx_data = head byte, combinational from FIFO storage.
  - Pop when tx_valid && tx_ready.
  - Push is accepted when count<TXQ_DEPTH, or when full with a pop in the same cycle; count is then unchanged.
  - A push to a full FIFO without a pop is dropped and sets sticky ovf. ovf is cleared only by a STATUS write or reset.
  - Pointers wrap modulo TXQ_DEPTH.
- Timer:
  - mtime increments by 1 every cycle and wraps 32'hFFFF_FFFF to 0.
  - timer_irq is registered: timer_irq <= (mtime >= mtimecmp), unsigned, using pre-increment mtime, so it lags by 1 cycle.
  - Writing mtimecmp above mtime deasserts timer_irq on the cycle after the write takes effect.

Optional Feature:
- Macro: DMEM_TIMER_EN.
- Defined: MTIME, MTIMECMP and timer_irq behave as above.
- Undefined: no timer registers; offsets 0x008/0x00C read 0 and ignore writes; timer_irq is tied to 0.

Decomposition:
- Package dmem_pkg holds: MMIO offset localparams (OFS_TXDATA, OFS_STATUS, OFS_MTIME, OFS_MTIMECMP), the region-select enum (REG_RAM, REG_MMIO), and the STATUS bit-position constants.
- Sub-module u_txq: parameterised byte FIFO with push/pop, count, full, empty and sticky ovf.
- RAM and timer stay inline.

Test Plan:
- Write 0xDEADBEEF to 0x0010 (we=4'hF), then write we=4'b0010 with wd=0x0000_5500, then read 0x0010 -> dat_rd=0xDEAD55EF one cycle after the read.
- Write 0x1234_5678 to 0x0010, then read 0x4010 with DEPTH_WORDS=4096 -> dat_rd=0x1234_5678 (address wraps).
- tx_ready=0, push 5 bytes 0x41..0x45 to 0xF000 -> STATUS read=0x0000_0304 (ovf=1, full=1, count=4). Raise tx_ready -> sink receives 0x41,0x42,0x43,0x44 on consecutive cycles.
- FIFO full with tx_ready=1 and a same-cycle push 0x46 -> push accepted, count stays 4, ovf unchanged, 0x46 emerges last.
- Timer enabled: write MTIME=0x0000_0000 and MTIMECMP=0x0000_0010 -> timer_irq rises on the 17th cycle after the MTIME write. Then write MTIMECMP=0xFFFF_FFFF -> timer_irq falls.
- Assert rst for one cycle while FIFO count=3 and a read is pending -> next cycle tx_valid=0, dat_rd=0, STATUS reads 0.
